fu_result_queue: RTL and testbench

Per-functional-unit result buffer sitting directly downstream of an execution unit (the one fed by the reservation station) and upstream of the common data bus (CDB) arbiter. It captures every `valid_out`/`result` the unit produces, together with its ROB tag, into a small FIFO. It then drains that FIFO onto the CDB under a request/grant handshake. It also drives an early stall back to the reservation station so the unit never produces a result the queue cannot hold.

---
 rtl/fu_result_queue.sv | 62 ++++++
 tb/tb_fu_result_queue.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/fu_result_queue.sv
// fu_result_queue: per-FU result FIFO draining onto the CDB via req/grant; define FU_RESULT_BYPASS_EN for empty-queue bypass
module fu_result_queue #(
    parameter int XLEN         = 32,
    parameter int TAG_W        = 7,
    parameter int QDEPTH       = 4,
    parameter int STALL_MARGIN = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fu_valid,
    input  logic [XLEN-1:0]  fu_result,
    input  logic [TAG_W-1:0] fu_tag,
    input  logic             fu_exc,
    input  logic             flush,
    output logic             cdb_req,
    input  logic             cdb_grant,
    output logic             cdb_valid,
    output logic [XLEN-1:0]  cdb_result,
    output logic [TAG_W-1:0] cdb_tag,
    output logic             cdb_exc,
    output logic             issue_stall,
    output logic             overflow
);
    localparam int PW = $clog2(QDEPTH);
    localparam int CW = $clog2(QDEPTH + 1);
    localparam int EW = XLEN + TAG_W + 1;
    logic [EW-1:0] mem [QDEPTH];
    logic [PW-1:0] head, tail;
    logic [CW-1:0] count, count_nxt;
    logic full, byp, push, pop;
    assign full = count == CW'(QDEPTH);
`ifdef FU_RESULT_BYPASS_EN
    assign byp = count == '0 && fu_valid && !flush;
`else
    assign byp = 1'b0;
`endif
    assign cdb_req   = (count != '0 || byp) && !flush;
    assign cdb_valid = cdb_req && cdb_grant;
    assign pop       = cdb_valid && count != '0;
    // a granted bypass result is consumed straight off the inputs and never stored
    assign push      = fu_valid && !flush && (!full || pop) && !(byp && cdb_grant);
    assign {cdb_result, cdb_tag, cdb_exc} = byp ? {fu_result, fu_tag, fu_exc} : mem[head];
    assign count_nxt = flush ? '0 : count + CW'(push) - CW'(pop);
    always_ff @(posedge clk) begin
        if (rst) begin
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            overflow    <= 1'b0;
            issue_stall <= 1'b0;
        end else begin
            head        <= flush ? '0 : head + PW'(pop);
            tail        <= flush ? '0 : tail + PW'(push);
            count       <= count_nxt;
            overflow    <= overflow || (fu_valid && !flush && full && !pop);
            issue_stall <= (CW'(QDEPTH) - count_nxt) <= CW'(STALL_MARGIN);
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem[tail] <= {fu_result, fu_tag, fu_exc};
    end
endmodule

// File: tb/tb_fu_result_queue.sv
// tb_fu_result_queue: queue-based reference model checked every cycle, plus directed literal checks and random traffic
module tb_fu_result_queue;
    localparam int XLEN = 32, TAG_W = 7, Q = 4, M = 2;
`ifdef FU_RESULT_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    typedef struct packed { logic [XLEN-1:0] res; logic [TAG_W-1:0] tag; logic exc; } ent_t;

    logic clk = 1'b0, rst = 1'b0, fu_valid = 1'b0, fu_exc = 1'b0, flush = 1'b0, cdb_grant = 1'b0;
    logic [XLEN-1:0] fu_result = '0;
    logic [TAG_W-1:0] fu_tag = '0;
    logic cdb_req, cdb_valid, cdb_exc, issue_stall, overflow;
    logic [XLEN-1:0] cdb_result;
    logic [TAG_W-1:0] cdb_tag;

    int total = 0, bad = 0;
    ent_t mq[$];
    int dut_bc[$];
    bit m_ovf = 0, m_stall = 0, armed = 0;

    fu_result_queue #(.XLEN(XLEN), .TAG_W(TAG_W), .QDEPTH(Q), .STALL_MARGIN(M)) dut (
        .clk(clk), .rst(rst), .fu_valid(fu_valid), .fu_result(fu_result), .fu_tag(fu_tag),
        .fu_exc(fu_exc), .flush(flush), .cdb_req(cdb_req), .cdb_grant(cdb_grant),
        .cdb_valid(cdb_valid), .cdb_result(cdb_result), .cdb_tag(cdb_tag), .cdb_exc(cdb_exc),
        .issue_stall(issue_stall), .overflow(overflow));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Inputs are stable from posedge+1 to the next posedge+1, so at negedge we both
    // check outputs and advance the model to the state the next posedge will produce.
    initial forever begin
        @(negedge clk);
        if (armed && !rst) begin
            automatic bit e_req = (mq.size() != 0 || (BYP && fu_valid)) && !flush;
            automatic bit e_val = e_req && cdb_grant;
            automatic ent_t h = mq.size() != 0 ? mq[0] : ent_t'({fu_result, fu_tag, fu_exc});
            chk("cdb_req", cdb_req, e_req);
            chk("cdb_valid", cdb_valid, e_val);
            chk("issue_stall", issue_stall, m_stall);
            chk("overflow", overflow, m_ovf);
            if (e_req) begin
                chk("cdb_result", cdb_result, h.res);
                chk("cdb_tag", cdb_tag, h.tag);
                chk("cdb_exc", cdb_exc, h.exc);
            end
            if (cdb_valid) dut_bc.push_back(int'(cdb_tag));
        end
        if (rst) begin
            mq.delete();
            m_ovf = 0;
            m_stall = 0;
            armed = 1;
        end else if (armed) begin
            if (flush) mq.delete();
            else begin
                automatic bit was_empty = mq.size() == 0;
                automatic bit e_val = (!was_empty || (BYP && fu_valid)) && cdb_grant;
                if (e_val && !was_empty) void'(mq.pop_front());
                if (fu_valid && !(BYP && was_empty && cdb_grant)) begin
                    if (mq.size() < Q) mq.push_back({fu_result, fu_tag, fu_exc});
                    else m_ovf = 1;
                end
            end
            m_stall = (Q - mq.size()) <= M;
        end
    end

    task automatic drive(input bit v, input int tag, input bit g, input bit f);
        fu_valid = v;
        fu_tag = TAG_W'(tag);
        fu_result = XLEN'(tag * 32'h11);
        fu_exc = tag[0];
        cdb_grant = g;
        flush = f;
    endtask

    task automatic step(input bit v, input int tag, input bit g, input bit f);
        drive(v, tag, g, f);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1;
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        rst = 0;
    endtask

    task automatic chk_seq(input string nm, input int exp[$]);
        chk({nm, "_len"}, dut_bc.size(), exp.size());
        for (int i = 0; i < exp.size() && i < dut_bc.size(); i++) chk(nm, dut_bc[i], exp[i]);
        dut_bc.delete();
    endtask

    initial begin
        @(posedge clk);
        #1;
        do_reset();
        repeat (3) step(0, 0, 0, 0);
        chk("rst_req", cdb_req, 0);
        chk("rst_stall", issue_stall, 0);
        chk("rst_ovf", overflow, 0);

        // in-order drain and stall hysteresis
        dut_bc.delete();
        step(1, 1, 0, 0);
        chk("stall_1push", issue_stall, 0);
        step(1, 2, 0, 0);
        chk("stall_2push", issue_stall, 1);
        step(1, 3, 0, 0);
        step(1, 4, 0, 0);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        chk("stall_2pop", issue_stall, 1);
        step(0, 0, 1, 0);
        chk("stall_3pop", issue_stall, 0);
        step(0, 0, 1, 0);
        chk("empty_req", cdb_req, 0);
        chk_seq("seq1234", '{1, 2, 3, 4});

        // push+pop when full, then drop, sticky through flush
        for (int t = 1; t <= 4; t++) step(1, t, 0, 0);
        step(1, 9, 1, 0);
        chk("full_pp_ovf", overflow, 0);
        chk("full_pp_stall", issue_stall, 1);
        step(1, 10, 0, 0);
        chk("drop_ovf", overflow, 1);
        step(0, 0, 0, 1);
        chk("flush_ovf", overflow, 1);
        chk("flush_req", cdb_req, 0);
        chk_seq("seq_full", '{1});

        // flush discards queue and concurrent push
        for (int t = 11; t <= 13; t++) step(1, t, 0, 0);
        drive(1, 5, 1, 1);
        #1;
        chk("flush_cyc_valid", cdb_valid, 0);
        @(posedge clk);
        #1;
        step(0, 0, 1, 0);
        chk("post_flush_req", cdb_req, 0);
        step(0, 0, 1, 0);
        chk_seq("seq_flush", '{});

        // pointer wrap with grant held
        do_reset();
        for (int t = 30; t < 40; t++) begin
            step(1, t, 1, 0);
            chk("wrap_stall", issue_stall, 0);
        end
        step(0, 0, 1, 0);
        chk("wrap_ovf", overflow, 0);
        chk_seq("seq_wrap", '{30, 31, 32, 33, 34, 35, 36, 37, 38, 39});

        // bypass vs. one-cycle latency on empty queue
        drive(1, 7, 1, 0);
        #1;
        chk("byp_valid", cdb_valid, BYP);
        @(posedge clk);
        #1;
        drive(0, 0, 1, 0);
        #1;
        chk("byp_next_valid", cdb_valid, !BYP);
        @(posedge clk);
        #1;
        chk_seq("seq_byp", '{7});

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            rst = $urandom_range(0, 199) == 0;
            step($urandom_range(0, 9) < 6, int'($urandom_range(0, 127)), $urandom_range(0, 1) == 1,
                 $urandom_range(0, 39) == 0);
        end
        rst = 0;
        step(0, 0, 0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
